// File: rtl/bm_dag3_result_fifo_pkg.sv
// Shared constants for the bm_dag3 result capture path.
// Holds the operand width, stored word width and default FIFO depth.
package bm_dag3_result_fifo_pkg;

    localparam int DAG_BITS   = 2;
    localparam int DAG_WORD   = DAG_BITS + 1;
    localparam int FIFO_DEPTH = 4;

    typedef logic [DAG_WORD-1:0] dag_word_t;

endpackage

// File: rtl/bm_dag3_fifo_mem.sv
// FIFO storage: DEPTH x W, one synchronous write port, one async read port.
// Ports: clock, we/waddr/wdata (write), raddr/rdata (read). No reset.
module bm_dag3_fifo_mem #(
    parameter int W     = 3,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bm_dag3_result_fifo.sv
// Result capture FIFO for the bm_dag3 DAG with valid/ready drain and
// optional running signature (macro BM_DAG3_RESULT_SIG_EN).
// Ports: clock, reset (async, active-high); in_valid/in_data0/in_data1/
// in_ready push side; out_valid/out_data/out_ready pop side; count,
// overflow (sticky), sig (0 when the signature is compiled out).
module bm_dag3_result_fifo
    import bm_dag3_result_fifo_pkg::*;
#(
    parameter int BITS  = DAG_BITS,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [BITS-1:0]          in_data0,
    input  logic                     in_data1,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [BITS:0]            out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [BITS:0]            sig
);

    localparam int W  = BITS + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  rdata;
    logic          push, pop;

    // Flags decode only registered occupancy, so in_ready never
    // depends combinationally on out_ready.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;
    assign overflow  = ovf_q;

    // Storage is unreset; mask the head so out_data reads 0 when empty.
    assign out_data = out_valid ? rdata : '0;

    bm_dag3_fifo_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({in_data1, in_data0}),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (in_valid && !in_ready) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef BM_DAG3_RESULT_SIG_EN
    logic [W-1:0] sig_q, sig_d;

    // Rotate left by one, then fold in the word being drained.
    always_comb begin
        sig_d = sig_q;
        if (pop) begin
            sig_d = {sig_q[BITS-1:0], sig_q[BITS]} ^ out_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`else
    assign sig = '0;
`endif

endmodule

// File: tb/tb_bm_dag3_result_fifo.sv
// Scoreboard bench for bm_dag3_result_fifo.
// Directed pushes queue expected words; a monitor checks every pop.
module tb_bm_dag3_result_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] in_data0;
    logic       in_data1;
    logic       in_ready;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;
    logic [2:0] sig;

    logic [2:0] exp_q [$];
    int ncmp = 0;
    int nerr = 0;
    int npop = 0;

    always #5 clock = ~clock;

    bm_dag3_result_fifo dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .sig       (sig)
    );

    task automatic chk(input string n, input int a, input int e);
        ncmp++;
        if (a != e) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // Monitor: handshake is stable at the falling edge.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            npop++;
            if (exp_q.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL pop_unexpected: got %0d expected none",
                         out_data);
            end else begin
                chk("pop_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    // One clock cycle of stimulus; acc is the hand-computed acceptance.
    task automatic drive(input logic v, input logic [2:0] w,
                         input logic r, input logic acc);
        in_valid  = v;
        in_data0  = w[1:0];
        in_data1  = w[2];
        out_ready = r;
        @(negedge clock);
        if (v) begin
            chk("in_ready", int'(in_ready), int'(acc));
            if (acc) exp_q.push_back(w);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string n);
        chk({n, "_count"}, int'(count), 0);
        chk({n, "_out_valid"}, int'(out_valid), 0);
        chk({n, "_in_ready"}, int'(in_ready), 1);
        chk({n, "_overflow"}, int'(overflow), 0);
        chk({n, "_sig"}, int'(sig), 0);
        chk({n, "_out_data"}, int'(out_data), 0);
    endtask

    initial begin
        logic [2:0] s1, s2;
`ifdef BM_DAG3_RESULT_SIG_EN
        s1 = 3'b001;
        s2 = 3'b001;
`else
        s1 = 3'b000;
        s2 = 3'b000;
`endif
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data0  = '0;
        in_data1  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // 1: idle after reset
        drive(0, 3'd0, 0, 0);
        chk_idle("t1");

        // 2: three pushes, then drain in order
        drive(1, 3'b101, 0, 1);
        drive(1, 3'b010, 0, 1);
        drive(1, 3'b111, 0, 1);
        chk("t2_count3", int'(count), 3);
        chk("t2_head", int'(out_data), 5);
        repeat (3) drive(0, 3'd0, 1, 0);
        chk("t2_count0", int'(count), 0);
        chk("t2_out_valid", int'(out_valid), 0);
        chk("t2_npop", npop, 3);

        // 4: steady push+pop at count=2, pointers wrap
        drive(1, 3'd1, 0, 1);
        drive(1, 3'd2, 0, 1);
        for (int i = 0; i < 8; i++) begin
            drive(1, 3'((i + 3) % 8), 1, 1);
            chk("t4_count", int'(count), 2);
        end
        chk("t4_overflow", int'(overflow), 0);
        drive(0, 3'd0, 1, 0);
        drive(0, 3'd0, 1, 0);
        chk("t4_count0", int'(count), 0);

        // 3: fill, offer a fifth word, drain exactly four
        drive(1, 3'd6, 0, 1);
        drive(1, 3'd5, 0, 1);
        drive(1, 3'd4, 0, 1);
        drive(1, 3'd3, 0, 1);
        chk("t3_count4", int'(count), 4);
        chk("t3_in_ready", int'(in_ready), 0);
        drive(1, 3'd1, 0, 0);
        chk("t3_overflow", int'(overflow), 1);
        chk("t3_count_held", int'(count), 4);
        repeat (4) drive(0, 3'd0, 1, 0);
        chk("t3_count0", int'(count), 0);
        chk("t3_out_valid", int'(out_valid), 0);
        chk("t3_overflow_sticky", int'(overflow), 1);

        // 5: async reset with count=3, overflow=1
        drive(1, 3'd7, 0, 1);
        drive(1, 3'd2, 0, 1);
        drive(1, 3'd4, 0, 1);
        chk("t5_count3", int'(count), 3);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk_idle("t5");
        exp_q.delete();
        @(posedge clock);
        #2 reset = 1'b0;
        #1;

        // 6: signature
        drive(1, 3'b001, 0, 1);
        drive(1, 3'b011, 0, 1);
        chk("t6_sig0", int'(sig), 0);
        drive(0, 3'd0, 1, 0);
        chk("t6_sig1", int'(sig), int'(s1));
        drive(0, 3'd0, 1, 0);
        chk("t6_sig2", int'(sig), int'(s2));
        chk("t6_count0", int'(count), 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
